// File: rtl/riscv_decode_stage.sv
// riscv_decode_stage: RV32I OP/OP-IMM decode into a registered ALU bundle with valid/ready handshake.
// Define DECODE_SKID_EN to add a one-entry skid register so that in_ready is driven from a register.
module riscv_decode_stage #(
    parameter int ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          instr,
    input  logic [31:0]          pc_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          pc_out,
    output logic [5:0]           alu_control,
    output logic [31:0]          imm_val,
    output logic [31:0]          shft_amnt,
    output logic [4:0]           rs1_addr,
    output logic [4:0]           rs2_addr,
    output logic [4:0]           rd_addr,
    output logic                 rd_we,
    output logic                 illegal,
    output logic [ILL_CNT_W-1:0] ill_cnt
);
    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  alu;
        logic [31:0] imm;
        logic [31:0] shamt;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } bundle_t;

    logic [6:0]     w_opcode;
    logic [2:0]     w_f3;
    logic [6:0]     w_f7;
    logic           w_legal;
    logic           w_is_imm;
    logic           w_is_shift;
    logic [5:0]     w_alu;
    bundle_t        w_dec;
    logic           w_acc;
    bundle_t        r_out;
    logic           r_out_valid;
    logic [ILL_CNT_W-1:0] r_ill_cnt;

    assign w_opcode = instr[6:0];
    assign w_f3     = instr[14:12];
    assign w_f7     = instr[31:25];

    always_comb begin
        w_legal    = 1'b1;
        w_is_imm   = 1'b0;
        w_is_shift = 1'b0;
        w_alu      = 6'b000000;
        case (w_opcode)
            7'b0110011: begin
                if (w_f7 == 7'b0000000) begin
                    case (w_f3)
                        3'b000: w_alu = 6'b000000;
                        3'b010: w_alu = 6'b000001;
                        3'b011: w_alu = 6'b000010;
                        3'b111: w_alu = 6'b000011;
                        3'b110: w_alu = 6'b000100;
                        3'b100: w_alu = 6'b000101;
                        3'b001: w_alu = 6'b000110;
                        3'b101: w_alu = 6'b000111;
                    endcase
                end else if (w_f7 == 7'b0100000 && w_f3 == 3'b000) begin
                    w_alu = 6'b001000;
                end else if (w_f7 == 7'b0100000 && w_f3 == 3'b101) begin
                    w_alu = 6'b001001;
                end else begin
                    w_legal = 1'b0;
                end
            end
            7'b0010011: begin
                w_is_imm = 1'b1;
                case (w_f3)
                    3'b000: w_alu = 6'b111111;
                    3'b010: w_alu = 6'b111110;
                    3'b011: w_alu = 6'b111101;
                    3'b111: w_alu = 6'b111100;
                    3'b110: w_alu = 6'b111011;
                    3'b100: w_alu = 6'b111010;
                    3'b001: begin
                        w_is_shift = 1'b1;
                        w_alu      = 6'b111001;
                        w_legal    = (w_f7 == 7'b0000000);
                    end
                    3'b101: begin
                        w_is_shift = 1'b1;
                        w_alu      = (w_f7 == 7'b0100000) ? 6'b110111 : 6'b111000;
                        w_legal    = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
                    end
                endcase
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Illegal words keep their register fields but zero every control/operand field.
    always_comb begin
        w_dec       = '0;
        w_dec.pc    = pc_in;
        w_dec.rs1   = instr[19:15];
        w_dec.rs2   = instr[24:20];
        w_dec.rd    = instr[11:7];
        w_dec.alu   = w_legal ? w_alu : 6'b000000;
        w_dec.imm   = (w_legal && w_is_imm) ? {{20{instr[31]}}, instr[31:20]} : 32'd0;
        w_dec.shamt = (w_legal && w_is_shift) ? {27'd0, instr[24:20]} : 32'd0;
        w_dec.we    = w_legal && (instr[11:7] != 5'd0);
        w_dec.ill   = !w_legal;
    end

    assign w_acc = in_valid && in_ready && !flush;

`ifdef DECODE_SKID_EN
    bundle_t r_skid;
    logic    r_skid_valid;
    logic    w_adv;

    assign in_ready = !r_skid_valid;
    assign w_adv    = !r_out_valid || out_ready;

    // Skid entry always drains before a new accept reaches the output, preserving order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out        <= '0;
            r_out_valid  <= 1'b0;
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_adv) begin
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_acc) begin
                r_out       <= w_dec;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_acc) begin
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
        end
    end
`else
    assign in_ready = !r_out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_acc) begin
            r_out       <= w_dec;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ill_cnt <= '0;
        end else if (w_acc && w_dec.ill && !(&r_ill_cnt)) begin
            r_ill_cnt <= r_ill_cnt + {{(ILL_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign out_valid   = r_out_valid;
    assign pc_out      = r_out.pc;
    assign alu_control = r_out.alu;
    assign imm_val     = r_out.imm;
    assign shft_amnt   = r_out.shamt;
    assign rs1_addr    = r_out.rs1;
    assign rs2_addr    = r_out.rs2;
    assign rd_addr     = r_out.rd;
    assign rd_we       = r_out.we;
    assign illegal     = r_out.ill;
    assign ill_cnt     = r_ill_cnt;
endmodule

// File: tb/tb_riscv_decode_stage.sv
// tb_riscv_decode_stage: directed checks of decode, handshake, flush, reset and illegal counter.
module tb_riscv_decode_stage;
    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] instr, pc_in;
    logic        in_ready, out_valid, rd_we, illegal;
    logic [31:0] pc_out, imm_val, shft_amnt;
    logic [5:0]  alu_control;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [7:0]  ill_cnt;
    logic        u2_in_ready, u2_out_valid, u2_rd_we, u2_illegal;
    logic [31:0] u2_pc_out, u2_imm_val, u2_shft_amnt;
    logic [5:0]  u2_alu_control;
    logic [4:0]  u2_rs1_addr, u2_rs2_addr, u2_rd_addr;
    logic [1:0]  u2_ill_cnt;
    int n_err = 0;
    int n_chk = 0;
    int acc_stall = 0;
    int nout = 0;
    int idx = 0;

    always #5 clk = ~clk;

    riscv_decode_stage #(.ILL_CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc_in(pc_in), .out_valid(out_valid), .out_ready(out_ready),
        .pc_out(pc_out), .alu_control(alu_control), .imm_val(imm_val), .shft_amnt(shft_amnt),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr), .rd_we(rd_we),
        .illegal(illegal), .ill_cnt(ill_cnt)
    );

    riscv_decode_stage #(.ILL_CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(u2_in_ready),
        .instr(instr), .pc_in(pc_in), .out_valid(u2_out_valid), .out_ready(out_ready),
        .pc_out(u2_pc_out), .alu_control(u2_alu_control), .imm_val(u2_imm_val),
        .shft_amnt(u2_shft_amnt), .rs1_addr(u2_rs1_addr), .rs2_addr(u2_rs2_addr),
        .rd_addr(u2_rd_addr), .rd_we(u2_rd_we), .illegal(u2_illegal), .ill_cnt(u2_ill_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] w, input logic [31:0] pc);
        instr    = w;
        pc_in    = pc;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] mk_addi(input int k);
        logic [31:0] kk;
        kk = k;
        return (kk << 20) | (kk << 7) | 32'h0000_0013;
    endfunction

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        instr = 32'd0; pc_in = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_alu", alu_control, 0);
        chk("rst_ill_cnt", ill_cnt, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(32'h002081B3, 32'h100);
        chk("add_valid", out_valid, 1);
        chk("add_alu", alu_control, 6'b000000);
        chk("add_rs1", rs1_addr, 1);
        chk("add_rs2", rs2_addr, 2);
        chk("add_rd", rd_addr, 3);
        chk("add_we", rd_we, 1);
        chk("add_ill", illegal, 0);
        chk("add_pc", pc_out, 32'h100);

        send(32'h407302B3, 32'h104);
        chk("sub_alu", alu_control, 6'b001000);
        chk("sub_rd", rd_addr, 5);
        chk("sub_rs1", rs1_addr, 6);
        chk("sub_rs2", rs2_addr, 7);
        chk("sub_imm", imm_val, 0);

        send(32'hFFF00093, 32'h108);
        chk("addi_alu", alu_control, 6'b111111);
        chk("addi_imm", imm_val, 32'hFFFF_FFFF);
        chk("addi_we", rd_we, 1);
        chk("addi_shamt", shft_amnt, 0);

        send(32'h4050D113, 32'h10C);
        chk("srai_alu", alu_control, 6'b110111);
        chk("srai_shamt", shft_amnt, 5);
        chk("srai_rd", rd_addr, 2);
        send(32'h0050D113, 32'h110);
        chk("srli_alu", alu_control, 6'b111000);
        chk("srli_shamt", shft_amnt, 5);

        send(32'h0000_0000, 32'h114);
        chk("ill1_cnt", ill_cnt, 1);
        send(32'h0000_0000, 32'h118);
        send(32'h0000_0000, 32'h11C);
        chk("ill_flag", illegal, 1);
        chk("ill_we", rd_we, 0);
        chk("ill_alu", alu_control, 0);
        chk("ill3_cnt", ill_cnt, 3);
        chk("ill3_cnt_w2", u2_ill_cnt, 3);
        send(32'h0000_0000, 32'h120);
        send(32'h0000_0000, 32'h124);
        chk("ill5_cnt", ill_cnt, 5);
        chk("ill5_sat_w2", u2_ill_cnt, 3);

        @(posedge clk);
        #1;
        chk("drain_valid", out_valid, 0);
        chk("drain_hold", illegal, 1);

        out_ready = 1'b0;
        send(32'h002081B3, 32'h200);
        chk("pre_flush_valid", out_valid, 1);
        out_ready = 1'b1; flush = 1'b1; in_valid = 1'b1; instr = 32'h0000_0000;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", out_valid, 0);
        chk("flush_ill_cnt", ill_cnt, 5);

        for (int c = 0; c < 24; c++) begin
            out_ready = !(c >= 2 && c <= 5);
            in_valid  = (idx < 6);
            instr     = mk_addi(idx + 1);
            #1;
            if (c >= 2 && c <= 5 && in_valid && in_ready) acc_stall++;
            if (c == 5) begin
                chk("stall_in_ready", in_ready, 0);
                chk("stall_rd", rd_addr, 2);
                chk("stall_valid", out_valid, 1);
            end
            if (out_valid && out_ready) begin
                chk("order_rd", rd_addr, nout + 1);
                chk("order_imm", imm_val, nout + 1);
                nout++;
            end
            if (in_valid && in_ready) idx++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("stream_count", nout, 6);
`ifdef DECODE_SKID_EN
        chk("stall_accepts", acc_stall, 1);
`else
        chk("stall_accepts", acc_stall, 0);
`endif
        chk("stream_idle", out_valid, 0);

        out_ready = 1'b0;
        send(32'h002081B3, 32'h300);
        in_valid = 1'b1; instr = 32'h407302B3;
        @(posedge clk);
        #1;
        chk("stall_before_rst", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_pc", pc_out, 0);
        chk("arst_rd", rd_addr, 0);
        chk("arst_we", rd_we, 0);
        chk("arst_ill_cnt", ill_cnt, 0);
        chk("arst_ill_cnt_w2", u2_ill_cnt, 0);
        in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
